// File: rtl/bfloat_pkg.sv
// Shared constants, sequencer state encoding and a lane slicing helper for
// the transpose sequencer and its neighbours.
package bfloat_pkg;

    localparam int WIDTH       = 16;
    localparam int NUMSTAGES   = 8;
    localparam int LOGNUMSTAGE = 3;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        WAIT_BUSY = 2'd1,
        DRAIN     = 2'd2
    } seq_state_e;

    function automatic logic [WIDTH-1:0] lane(input logic [NUMSTAGES*WIDTH-1:0] v,
                                              input int k);
        return v[k*WIDTH +: WIDTH];
    endfunction

endpackage

// File: rtl/transpose_seq_if.sv
// Row input stream, column output stream and the transpose-unit side signals.
// slave = the sequencer, master = whatever drives it (bench or surrounding logic).
interface transpose_seq_if #(
    parameter int WIDTH     = bfloat_pkg::WIDTH,
    parameter int NUMSTAGES = bfloat_pkg::NUMSTAGES
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUMSTAGES*WIDTH-1:0] in_data;
    logic                       tr_en;
    logic                       tr_read;
    logic [NUMSTAGES*WIDTH-1:0] tr_a;
    logic [NUMSTAGES*WIDTH-1:0] tr_out;
    logic                       tr_busy;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUMSTAGES*WIDTH-1:0] out_data;
    logic                       out_last;

    modport slave (
        input  in_valid, in_data, out_ready, tr_out, tr_busy,
        output in_ready, tr_en, tr_read, tr_a, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready, tr_out, tr_busy,
        input  in_ready, tr_en, tr_read, tr_a, out_valid, out_data, out_last
    );
endinterface

// File: rtl/col_skid_fifo.sv
// Two-entry column buffer; entry 0 is always the head. The caller's credit
// scheme guarantees no push lands on a full buffer without a matching pop.
module col_skid_fifo #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         last_i,
    input  logic         pop_i,
    output logic [1:0]   occ_o,
    output logic [W-1:0] head_o,
    output logic         head_last_o
);
    logic [W-1:0] d0_q, d1_q;
    logic         l0_q, l1_q;
    logic [1:0]   occ_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d0_q  <= '0;
            d1_q  <= '0;
            l0_q  <= 1'b0;
            l1_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        d0_q <= din_i;
                        l0_q <= last_i;
                    end else begin
                        d1_q <= din_i;
                        l1_q <= last_i;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    d0_q  <= d1_q;
                    l0_q  <= l1_q;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; the new column replaces or follows the head
                    if (occ_q == 2'd2) begin
                        d0_q <= d1_q;
                        l0_q <= l1_q;
                        d1_q <= din_i;
                        l1_q <= last_i;
                    end else begin
                        d0_q <= din_i;
                        l0_q <= last_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ_o       = occ_q;
    assign head_o      = d0_q;
    assign head_last_o = l0_q;
endmodule

// File: rtl/transpose_seq.sv
// Fills the transpose unit with one tile of rows, then drains its columns into
// a 2-entry buffer under a credit scheme so output backpressure never drops data.
module transpose_seq #(
    parameter int WIDTH       = bfloat_pkg::WIDTH,
    parameter int NUMSTAGES   = bfloat_pkg::NUMSTAGES,
    parameter int LOGNUMSTAGE = bfloat_pkg::LOGNUMSTAGE
) (
    input logic             clk,
    input logic             resetn,
    transpose_seq_if.slave  io
);
    import bfloat_pkg::*;

    localparam int             CW       = LOGNUMSTAGE + 1;
    localparam logic [CW-1:0]  N_CNT    = CW'(NUMSTAGES);
    localparam logic [CW-1:0]  ROW_LAST = CW'(NUMSTAGES - 1);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          inflight_q;
    logic [1:0]    occ;
    logic [2:0]    credit;
    logic          pop, accept, rd, drain_done, head_last;

    assign pop        = io.out_valid & io.out_ready;
    assign drain_done = (state_q == DRAIN) && (rd_cnt_q == N_CNT) && !inflight_q && !io.tr_busy;

    // The drain-exit cycle already accepts the next tile's first row.
    assign io.in_ready = resetn & ((state_q == FILL) | drain_done);
    assign accept      = io.in_valid & io.in_ready;
    assign io.tr_en    = accept;
    assign io.tr_a     = resetn ? io.in_data : '0;

    // Slots committed after this cycle: stored, minus leaving, plus the read in flight.
    assign credit     = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight_q};
    assign rd         = (state_q == DRAIN) && (rd_cnt_q < N_CNT) && (credit < 3'd2);
    assign io.tr_read = rd;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        state_d   = WAIT_BUSY;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_BUSY: begin
                if (io.tr_busy) state_d = DRAIN;
            end
            DRAIN: begin
                if (rd) rd_cnt_d = rd_cnt_q + 1'b1;
                if (drain_done) begin
                    state_d   = FILL;
                    rd_cnt_d  = '0;
                    row_cnt_d = accept ? CW'(1) : '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= FILL;
            row_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            inflight_q <= rd;
        end
    end

    // A column lands the cycle after its read; rd_cnt has already advanced past it.
    col_skid_fifo #(.W(NUMSTAGES*WIDTH)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (inflight_q),
        .din_i       (io.tr_out),
        .last_i      (rd_cnt_q == N_CNT),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (io.out_data),
        .head_last_o (head_last)
    );

    assign io.out_valid = (occ != 2'd0);
    assign io.out_last  = head_last & io.out_valid;
endmodule

// File: tb/tb_transpose_seq.sv
// Directed bench for transpose_seq with a behavioural transpose unit attached.
module tb_transpose_seq;
    import bfloat_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    transpose_seq_if io ();

    transpose_seq dut (.clk(clk), .resetn(resetn), .io(io));

    int tests = 0;
    int fails = 0;

    // Behavioural transpose unit: en writes rows, busy once full, read shifts out columns.
    logic [WIDTH-1:0]           mem [NUMSTAGES][NUMSTAGES];
    int                         wcnt, rcnt;
    logic                       busy_m;
    logic [NUMSTAGES*WIDTH-1:0] tout;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wcnt   <= 0;
            rcnt   <= 0;
            busy_m <= 1'b0;
            tout   <= '0;
        end else begin
            if (io.tr_en && !busy_m) begin
                for (int k = 0; k < NUMSTAGES; k++) mem[wcnt][k] <= lane(io.tr_a, k);
                if (wcnt == NUMSTAGES-1) begin
                    wcnt   <= 0;
                    busy_m <= 1'b1;
                end else wcnt <= wcnt + 1;
            end
            if (io.tr_read && busy_m) begin
                for (int i = 0; i < NUMSTAGES; i++) tout[i*WIDTH +: WIDTH] <= mem[i][rcnt];
                if (rcnt == NUMSTAGES-1) begin
                    rcnt   <= 0;
                    busy_m <= 1'b0;
                end else rcnt <= rcnt + 1;
            end
        end
    end
    assign io.tr_out  = tout;
    assign io.tr_busy = busy_m;

    // Cycle-stamped monitor, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                         en_cnt = 0;
    int                         rd_m = 0;
    logic [NUMSTAGES*WIDTH-1:0] col_data [$];
    bit                         col_last [$];
    int                         col_cyc  [$];
    bit                         ir_log [int];
    bit                         rd_log [int];

    always @(negedge clk) begin
        ir_log[cyc] = io.in_ready;
        rd_log[cyc] = io.tr_read;
        if (io.tr_en) en_cnt++;
        if (io.tr_read) rd_m++;
        if (io.out_valid && io.out_ready) begin
            col_data.push_back(io.out_data);
            col_last.push_back(io.out_last);
            col_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] elem(input int tag, input int r, input int c);
        return 16'((tag << 12) | (r << 8) | c);
    endfunction

    function automatic logic [NUMSTAGES*WIDTH-1:0] exp_col(input int tag, input int j);
        logic [NUMSTAGES*WIDTH-1:0] v;
        for (int i = 0; i < NUMSTAGES; i++) v[i*WIDTH +: WIDTH] = elem(tag, i, j);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends NUMSTAGES rows; t = cycle of the last accept. Returns at the drive point of t+1.
    task automatic send_tile(input int tag, input bit gapped, output int t, output bit ok);
        ok = 1'b1;
        t  = 0;
        for (int r = 0; r < NUMSTAGES; r++) begin
            bit got;
            got = 1'b0;
            if (gapped && r > 0) begin
                io.in_valid = 1'b0;
                tick();
            end
            io.in_valid = 1'b1;
            for (int k = 0; k < NUMSTAGES; k++) io.in_data[k*WIDTH +: WIDTH] = elem(tag, r, k);
            for (int w = 0; w < 300 && !got; w++) begin
                @(negedge clk);
                if (io.in_ready) begin
                    got = 1'b1;
                    t   = cyc;
                end
                @(posedge clk);
                #1;
            end
            if (!got) begin
                ok = 1'b0;
                break;
            end
        end
        io.in_valid = 1'b0;
    endtask

    task automatic wait_cols(input int n, output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 2000; w++) begin
            if (col_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        io.in_valid = 1'b1;
        io.in_data  = {NUMSTAGES{16'h5A5A}};
        io.out_ready = 1'b1;
        #1;
        tests++;
        if ({io.in_ready, io.tr_en, io.tr_read, io.out_valid, io.out_last} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000", {io.in_ready, io.tr_en, io.tr_read, io.out_valid, io.out_last});
        end
        tests++;
        if (io.tr_a !== '0 || io.out_data !== '0) begin
            fails++;
            $display("FAIL reset_data: tr_a=%h out_data=%h want 0", io.tr_a, io.out_data);
        end
        @(posedge clk);
        #2;
        resetn = 1'b1;
        #1;
        tests++;
        if (io.in_ready !== 1'b1 || io.tr_a !== io.in_data || io.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b tr_a=%h want 1 0 %h",
                     io.in_ready, io.out_valid, io.tr_a, io.in_data);
        end
        io.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_tile();
        int t, base, en0, rd0;
        bit ok;
        base = col_data.size();
        en0 = en_cnt;
        rd0 = rd_m;
        io.out_ready = 1'b1;
        send_tile(0, 1'b0, t, ok);
        if (ok) wait_cols(base + NUMSTAGES, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL single_timeout: got %0d columns want %0d", col_data.size() - base, NUMSTAGES);
            return;
        end
        tick(); tick();
        for (int j = 0; j < NUMSTAGES; j++) begin
            tests++;
            if (col_data[base+j] !== exp_col(0, j) || col_last[base+j] !== (j == NUMSTAGES-1) ||
                col_cyc[base+j] !== t + 4 + j) begin
                fails++;
                $display("FAIL single_col%0d: data=%h last=%b cyc=%0d want %h %b %0d", j,
                         col_data[base+j], col_last[base+j], col_cyc[base+j] - t,
                         exp_col(0, j), j == NUMSTAGES-1, 4 + j);
            end
        end
        tests++;
        if (ir_log[t+10] !== 1'b0 || ir_log[t+11] !== 1'b1) begin
            fails++;
            $display("FAIL single_in_ready: t+10=%b t+11=%b want 0 1", ir_log[t+10], ir_log[t+11]);
        end
        tests++;
        if (rd_log[t+1] !== 1'b0 || rd_log[t+2] !== 1'b1 || rd_log[t+9] !== 1'b1 || rd_log[t+10] !== 1'b0 ||
            rd_m - rd0 !== NUMSTAGES) begin
            fails++;
            $display("FAIL single_reads: t+1..=%b%b%b%b count=%0d want 0110 %0d",
                     rd_log[t+1], rd_log[t+2], rd_log[t+9], rd_log[t+10], rd_m - rd0, NUMSTAGES);
        end
        tests++;
        if (en_cnt - en0 !== NUMSTAGES) begin
            fails++;
            $display("FAIL single_en: got %0d want %0d", en_cnt - en0, NUMSTAGES);
        end
    endtask

    task automatic test_stall();
        int t, base, rd0;
        bit ok;
        base = col_data.size();
        rd0 = rd_m;
        io.out_ready = 1'b1;
        send_tile(1, 1'b0, t, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_send: tile not accepted");
            return;
        end
        tick(); tick();
        io.out_ready = 1'b0;   // cycles t+3 .. t+20
        repeat (18) tick();
        // Reads at t+2 and t+3 were already committed; both columns sit in the buffer.
        tests++;
        if (rd_m - rd0 !== 2 || col_data.size() !== base) begin
            fails++;
            $display("FAIL stall_hold: reads=%0d popped=%0d want 2 0", rd_m - rd0, col_data.size() - base);
        end
        tests++;
        if (io.out_valid !== 1'b1 || io.out_data !== exp_col(1, 0)) begin
            fails++;
            $display("FAIL stall_head: valid=%b data=%h want 1 %h", io.out_valid, io.out_data, exp_col(1, 0));
        end
        io.out_ready = 1'b1;
        wait_cols(base + NUMSTAGES, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_timeout: got %0d columns want %0d", col_data.size() - base, NUMSTAGES);
            return;
        end
        repeat (4) tick();
        tests++;
        if (col_data.size() - base !== NUMSTAGES || rd_m - rd0 !== NUMSTAGES || rd_log[t+21] !== 1'b1) begin
            fails++;
            $display("FAIL stall_counts: cols=%0d reads=%0d resume=%b want %0d %0d 1",
                     col_data.size() - base, rd_m - rd0, rd_log[t+21], NUMSTAGES, NUMSTAGES);
        end
        for (int j = 0; j < NUMSTAGES; j++) begin
            tests++;
            if (col_data[base+j] !== exp_col(1, j) || col_last[base+j] !== (j == NUMSTAGES-1) ||
                col_cyc[base+j] !== t + 21 + j) begin
                fails++;
                $display("FAIL stall_col%0d: data=%h last=%b cyc=%0d want %h %b %0d", j,
                         col_data[base+j], col_last[base+j], col_cyc[base+j] - t,
                         exp_col(1, j), j == NUMSTAGES-1, 21 + j);
            end
        end
    endtask

    task automatic test_gapped();
        int t, base, en0;
        bit ok;
        base = col_data.size();
        en0 = en_cnt;
        io.out_ready = 1'b1;
        send_tile(0, 1'b1, t, ok);
        if (ok) wait_cols(base + NUMSTAGES, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL gapped_timeout: got %0d columns", col_data.size() - base);
            return;
        end
        tick();
        tests++;
        if (en_cnt - en0 !== NUMSTAGES) begin
            fails++;
            $display("FAIL gapped_en: got %0d want %0d", en_cnt - en0, NUMSTAGES);
        end
        for (int j = 0; j < NUMSTAGES; j++) begin
            tests++;
            if (col_data[base+j] !== exp_col(0, j) || col_last[base+j] !== (j == NUMSTAGES-1) ||
                col_cyc[base+j] !== t + 4 + j) begin
                fails++;
                $display("FAIL gapped_col%0d: data=%h last=%b cyc=%0d want %h %b %0d", j,
                         col_data[base+j], col_last[base+j], col_cyc[base+j] - t,
                         exp_col(0, j), j == NUMSTAGES-1, 4 + j);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ta, tb, base, en0, bad;
        bit ok_a, ok_b, ok;
        base = col_data.size();
        en0 = en_cnt;
        io.out_ready = 1'b1;
        send_tile(4'hA, 1'b0, ta, ok_a);
        send_tile(4'hB, 1'b0, tb, ok_b);
        ok = ok_a && ok_b;
        if (ok) wait_cols(base + 2*NUMSTAGES, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_timeout: got %0d columns want %0d", col_data.size() - base, 2*NUMSTAGES);
            return;
        end
        tick(); tick();
        bad = 0;
        for (int k = 1; k <= 10; k++) if (ir_log[ta+k] !== 1'b0) bad++;
        tests++;
        if (bad !== 0 || ir_log[ta+11] !== 1'b1 || tb !== ta + 18) begin
            fails++;
            $display("FAIL b2b_in_ready: high_in_gap=%0d t+11=%b tileB_end=%0d want 0 1 18",
                     bad, ir_log[ta+11], tb - ta);
        end
        tests++;
        if (en_cnt - en0 !== 2*NUMSTAGES) begin
            fails++;
            $display("FAIL b2b_en: got %0d want %0d", en_cnt - en0, 2*NUMSTAGES);
        end
        for (int j = 0; j < 2*NUMSTAGES; j++) begin
            int tag, jj;
            tag = (j < NUMSTAGES) ? 4'hA : 4'hB;
            jj  = j % NUMSTAGES;
            tests++;
            if (col_data[base+j] !== exp_col(tag, jj) || col_last[base+j] !== (jj == NUMSTAGES-1)) begin
                fails++;
                $display("FAIL b2b_col%0d: data=%h last=%b want %h %b", j,
                         col_data[base+j], col_last[base+j], exp_col(tag, jj), jj == NUMSTAGES-1);
            end
        end
    endtask

    task automatic test_random_ready();
        int base, t;
        bit ok, all_ok, done;
        base = col_data.size();
        all_ok = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 20; n++) begin
                    send_tile(n & 15, 1'b0, t, ok);
                    if (!ok) all_ok = 1'b0;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    io.out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        io.out_ready = 1'b1;
        wait_cols(base + 20*NUMSTAGES, ok);
        tests++;
        if (!(ok && all_ok)) begin
            fails++;
            $display("FAIL random_timeout: got %0d columns want %0d", col_data.size() - base, 20*NUMSTAGES);
            return;
        end
        repeat (4) tick();
        tests++;
        if (col_data.size() - base !== 20*NUMSTAGES) begin
            fails++;
            $display("FAIL random_count: got %0d columns want %0d", col_data.size() - base, 20*NUMSTAGES);
        end
        for (int n = 0; n < 20; n++) begin
            int mism, nlast;
            mism = 0;
            nlast = 0;
            for (int j = 0; j < NUMSTAGES; j++) begin
                if (col_data[base + n*NUMSTAGES + j] !== exp_col(n & 15, j)) mism++;
                if (col_last[base + n*NUMSTAGES + j]) nlast++;
            end
            tests++;
            if (mism !== 0 || nlast !== 1 || col_last[base + n*NUMSTAGES + NUMSTAGES-1] !== 1'b1) begin
                fails++;
                $display("FAIL random_tile%0d: bad_cols=%0d lasts=%0d want 0 1", n, mism, nlast);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int t, base;
        bit ok;
        base = col_data.size();
        io.out_ready = 1'b1;
        send_tile(5, 1'b0, t, ok);
        if (ok) wait_cols(base + 3, ok);
        tests++;
        if (!ok || io.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_setup: ok=%b out_valid=%b want 1 1", ok, io.out_valid);
            return;
        end
        io.in_valid = 1'b1;
        io.in_data  = {NUMSTAGES{16'hC3C3}};
        #1;
        resetn = 1'b0;
        #1;
        tests++;
        if ({io.in_ready, io.tr_en, io.tr_read, io.out_valid, io.out_last} !== 5'b0 ||
            io.tr_a !== '0 || io.out_data !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: ctrl=%b tr_a=%h out_data=%h want 0",
                     {io.in_ready, io.tr_en, io.tr_read, io.out_valid, io.out_last}, io.tr_a, io.out_data);
        end
        io.in_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        base = col_data.size();
        send_tile(6, 1'b0, t, ok);
        if (ok) wait_cols(base + NUMSTAGES, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL mid_retile_timeout: got %0d columns", col_data.size() - base);
            return;
        end
        tick();
        tests++;
        if (col_cyc[base] !== t + 4) begin
            fails++;
            $display("FAIL mid_first_valid: got t+%0d want t+4", col_cyc[base] - t);
        end
        for (int j = 0; j < NUMSTAGES; j++) begin
            tests++;
            if (col_data[base+j] !== exp_col(6, j) || col_last[base+j] !== (j == NUMSTAGES-1)) begin
                fails++;
                $display("FAIL mid_col%0d: data=%h last=%b want %h %b", j,
                         col_data[base+j], col_last[base+j], exp_col(6, j), j == NUMSTAGES-1);
            end
        end
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.out_ready = 1'b1;
        test_reset();
        test_single_tile();
        test_stall();
        test_gapped();
        test_back_to_back();
        test_random_ready();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
